// File: rtl/mem_arbiter_pkg.sv
// cache_definition: types shared by the caches, the SRAM controller and
// the memory arbiter.
//   cache_to_mem_type : request channel (addr, data, rw, valid)
//   mem_to_cache_type : response channel (data, ready)
//   arb_state_type    : arbiter FSM states
//   ARB_TIMEOUT_DEFAULT : default watchdog length in WAIT cycles
package cache_definition;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cache_to_mem_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } mem_to_cache_type;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_type;

  localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both cache channels, the memory-side channel and
// the arbiter status outputs.
//   req0/rsp0     : I-cache request / response
//   req1/rsp1     : D-cache request / response
//   mem_req/rsp   : SRAM controller request / response
//   grant         : one-hot owner of the memory channel
//   busy          : transaction in flight
//   timeout_err   : sticky watchdog abort flag
// Modport slave is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  import cache_definition::*;

  cache_to_mem_type req0;
  cache_to_mem_type req1;
  cache_to_mem_type mem_req;
  mem_to_cache_type rsp0;
  mem_to_cache_type rsp1;
  mem_to_cache_type mem_rsp;
  logic [1:0]       grant;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  req0, req1, mem_rsp,
    output rsp0, rsp1, mem_req, grant, busy, timeout_err
  );

  modport master (
    output req0, req1, mem_rsp,
    input  rsp0, rsp1, mem_req, grant, busy, timeout_err
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser.
//   i_valid0, i_valid1 : requests from port 0 / port 1
//   i_lastGrant        : port that owned the last transaction (0 or 1)
//   o_grant            : one-hot choice, 0 when nobody requests
module rr_pick2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_lastGrant,
  output logic [1:0] o_grant
);

  // On a tie the port that was not served last time wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_lastGrant ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM controller between the I-cache (port 0) and
// the D-cache (port 1) with round-robin fairness and a completion watchdog.
//   clk    : clock
//   rst    : synchronous active-low reset
//   io_bus : mem_arbiter_if.slave (both cache channels, memory channel,
//            grant, busy, timeout_err)
module mem_arbiter
  import cache_definition::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   io_bus
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  arb_state_type    r_state;
  arb_state_type    w_nextState;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic             r_rw;
  logic [1:0]       r_grant;
  logic             r_lastGrant;
  logic [7:0]       r_count;
  logic             r_timeoutErr;

  logic [1:0]       w_pick;
  logic             w_complete;
  logic             w_abort;
  mem_to_cache_type w_rsp;
  mem_to_cache_type w_rsp0;
  mem_to_cache_type w_rsp1;
  cache_to_mem_type w_memReq;

  rr_pick2 u_pick (
    .i_valid0    (io_bus.req0.valid),
    .i_valid1    (io_bus.req1.valid),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_pick)
  );

  // Next state and response routing. The memory response is only looked at
  // in WAIT; a real response beats a watchdog abort in the same cycle.
  always_comb begin
    w_nextState    = r_state;
    w_complete     = 1'b0;
    w_abort        = 1'b0;
    w_rsp          = '0;
    w_rsp0         = '0;
    w_rsp1         = '0;
    w_memReq       = '0;
    w_memReq.addr  = r_addr;
    w_memReq.data  = r_data;
    w_memReq.rw    = r_rw;

    case (r_state)
      IDLE: begin
        if (w_pick != 2'b00) begin
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        // Single-cycle pulse: a second cycle would start a second access.
        w_memReq.valid = 1'b1;
        w_nextState    = WAIT;
      end
      WAIT: begin
        if (io_bus.mem_rsp.ready) begin
          w_complete  = 1'b1;
          w_rsp.ready = 1'b1;
          w_rsp.data  = io_bus.mem_rsp.data;
          w_nextState = IDLE;
        end else if (r_count == LAST_COUNT) begin
          w_abort     = 1'b1;
          w_rsp.ready = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (r_grant[0]) begin
      w_rsp0 = w_rsp;
    end
    if (r_grant[1]) begin
      w_rsp1 = w_rsp;
    end
  end

  // State, latched request, ownership, fairness history, watchdog counter
  // and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_rw         <= 1'b0;
      r_grant      <= 2'b00;
      r_lastGrant  <= 1'b1;
      r_count      <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_pick != 2'b00) begin
            r_grant <= w_pick;
            if (w_pick[0]) begin
              r_addr <= io_bus.req0.addr;
              r_data <= io_bus.req0.data;
              r_rw   <= io_bus.req0.rw;
            end else begin
              r_addr <= io_bus.req1.addr;
              r_data <= io_bus.req1.data;
              r_rw   <= io_bus.req1.rw;
            end
          end
        end
        ISSUE: begin
          r_count <= '0;
        end
        WAIT: begin
          if (w_complete || w_abort) begin
            r_grant     <= 2'b00;
            r_lastGrant <= r_grant[1];
            if (w_abort) begin
              r_timeoutErr <= 1'b1;
            end
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.mem_req     = w_memReq;
  assign io_bus.rsp0        = w_rsp0;
  assign io_bus.rsp1        = w_rsp1;
  assign io_bus.grant       = r_grant;
  assign io_bus.busy        = (r_state != IDLE);
  assign io_bus.timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// A cycle table covers single read/write transactions, followed by
// hand-written tie/alternation, watchdog and mid-transaction reset sequences,
// then a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import cache_definition::*;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] A0 = 32'h0000_0040;
  localparam logic [31:0] D0 = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0001_2345;
  localparam logic [31:0] D1 = 32'hA5A5_A5A5;

  typedef struct {
    logic        v0;
    logic        v1;
    logic        mrdy;
    logic [31:0] mdata;
    logic [1:0]  eGrant;
    logic        eBusy;
    logic        eMemV;
    logic        eR0;
    logic        eR1;
    logic [31:0] eData;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] eGrant, input logic eBusy,
                          input logic eMemV, input logic eR0, input logic [31:0] eD0,
                          input logic eR1, input logic [31:0] eD1, input logic eTo);
    checkOutput({tag, " grant"},       64'(bus.grant),         64'(eGrant));
    checkOutput({tag, " busy"},        64'(bus.busy),          64'(eBusy));
    checkOutput({tag, " mem_valid"},   64'(bus.mem_req.valid), 64'(eMemV));
    checkOutput({tag, " rsp0.ready"},  64'(bus.rsp0.ready),    64'(eR0));
    checkOutput({tag, " rsp0.data"},   64'(bus.rsp0.data),     64'(eD0));
    checkOutput({tag, " rsp1.ready"},  64'(bus.rsp1.ready),    64'(eR1));
    checkOutput({tag, " rsp1.data"},   64'(bus.rsp1.data),     64'(eD1));
    checkOutput({tag, " timeout_err"}, 64'(bus.timeout_err),   64'(eTo));
  endtask

  task automatic checkReq(input string tag, input logic [31:0] a, input logic [31:0] d, input logic rw);
    checkOutput({tag, " mem_addr"}, 64'(bus.mem_req.addr), 64'(a));
    checkOutput({tag, " mem_data"}, 64'(bus.mem_req.data), 64'(d));
    checkOutput({tag, " mem_rw"},   64'(bus.mem_req.rw),   64'(rw));
  endtask

  task automatic applyStimulus(input cache_to_mem_type r0, input cache_to_mem_type r1,
                               input mem_to_cache_type m);
    bus.req0    = r0;
    bus.req1    = r1;
    bus.mem_rsp = m;
  endtask

  function automatic cache_to_mem_type mkReq(input logic v, input logic [31:0] a,
                                             input logic [31:0] d, input logic rw);
    cache_to_mem_type r;
    r.addr  = a;
    r.data  = d;
    r.rw    = rw;
    r.valid = v;
    return r;
  endfunction

  function automatic mem_to_cache_type mkRsp(input logic rdy, input logic [31:0] d);
    mem_to_cache_type r;
    r.data  = d;
    r.ready = rdy;
    return r;
  endfunction

  function automatic vec_t mkVec(input logic v0, input logic v1, input logic mrdy,
                                 input logic [31:0] mdata, input logic [1:0] eGrant,
                                 input logic eBusy, input logic eMemV, input logic eR0,
                                 input logic eR1, input logic [31:0] eData);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.mrdy = mrdy; v.mdata = mdata;
    v.eGrant = eGrant; v.eBusy = eBusy; v.eMemV = eMemV;
    v.eR0 = eR0; v.eR1 = eR1; v.eData = eData;
    return v;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus('0, '0, '0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
  endtask

  vec_t vecs[11];

  initial begin
    rst = 1'b0;
    applyStimulus('0, '0, '0);
    #1;
    nextCycle();
    nextCycle();
    rst = 1'b1;

    // Reset state.
    settle();
    checkAll("reset", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkReq("reset", 32'h0, 32'h0, 1'b0);
    nextCycle();

    // Port 0 read, then port 1 write; stray memory ready outside WAIT.
    vecs[0]  = mkVec(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mkVec(1, 0, 0, 32'h0,         2'b01, 1, 1, 0, 0, 32'h0);
    vecs[2]  = mkVec(1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 0, 32'h0);
    vecs[3]  = mkVec(1, 0, 1, 32'hDEADBEEF,  2'b01, 1, 0, 1, 0, 32'hDEADBEEF);
    vecs[4]  = mkVec(0, 0, 1, 32'h12121212,  2'b00, 0, 0, 0, 0, 32'h0);
    vecs[5]  = mkVec(0, 1, 1, 32'h34343434,  2'b00, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mkVec(0, 1, 1, 32'h56565656,  2'b10, 1, 1, 0, 0, 32'h0);
    vecs[7]  = mkVec(0, 1, 0, 32'h0,         2'b10, 1, 0, 0, 0, 32'h0);
    vecs[8]  = mkVec(0, 1, 0, 32'h0,         2'b10, 1, 0, 0, 0, 32'h0);
    vecs[9]  = mkVec(0, 1, 1, 32'h11112222,  2'b10, 1, 0, 0, 1, 32'h11112222);
    vecs[10] = mkVec(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(mkReq(vecs[i].v0, A0, D0, 1'b0), mkReq(vecs[i].v1, A1, D1, 1'b1),
                    mkRsp(vecs[i].mrdy, vecs[i].mdata));
      settle();
      checkAll(tag, vecs[i].eGrant, vecs[i].eBusy, vecs[i].eMemV,
               vecs[i].eR0, vecs[i].eR0 ? vecs[i].eData : 32'h0,
               vecs[i].eR1, vecs[i].eR1 ? vecs[i].eData : 32'h0, 1'b0);
      if (vecs[i].eGrant == 2'b01) checkReq(tag, A0, D0, 1'b0);
      if (vecs[i].eGrant == 2'b10) checkReq(tag, A1, D1, 1'b1);
      nextCycle();
    end

    // Tie after reset, then continuous requests: strict alternation 0,1,0,1,0,1.
    doReset();
    for (int t = 0; t < 6; t++) begin
      logic [1:0]  expG;
      logic [31:0] md;
      string       tag;
      expG = (t % 2 == 0) ? 2'b01 : 2'b10;
      md   = 32'h1000 + 32'(t);
      tag  = $sformatf("alt%0d", t);
      applyStimulus(mkReq(1, A0, D0, 1'b0), mkReq(1, A1, D1, 1'b1), mkRsp(0, 32'h0));
      settle();
      checkAll({tag, " idle"}, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      nextCycle();
      settle();
      checkAll({tag, " issue"}, expG, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      nextCycle();
      bus.mem_rsp = mkRsp(1, md);
      settle();
      checkAll({tag, " wait"}, expG, 1'b1, 1'b0, expG[0], expG[0] ? md : 32'h0,
               expG[1], expG[1] ? md : 32'h0, 1'b0);
      nextCycle();
    end

    // Watchdog: memory never answers.
    doReset();
    applyStimulus(mkReq(1, A0, D0, 1'b0), mkReq(0, A1, D1, 1'b1), mkRsp(0, 32'h0));
    nextCycle();
    nextCycle();
    for (int w = 1; w <= TIMEOUT; w++) begin
      settle();
      if (w < TIMEOUT) begin
        checkOutput($sformatf("to wait%0d rsp0.ready", w), 64'(bus.rsp0.ready), 64'(1'b0));
      end else begin
        checkAll("to abort", 2'b01, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      end
      nextCycle();
    end
    bus.req0.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checkAll($sformatf("to sticky%0d", k), 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      nextCycle();
    end

    // Reset in the middle of WAIT, then a late memory ready.
    applyStimulus(mkReq(0, A0, D0, 1'b0), mkReq(1, A1, D1, 1'b1), mkRsp(0, 32'h0));
    nextCycle();
    nextCycle();
    nextCycle();
    settle();
    checkOutput("rstwait busy", 64'(bus.busy), 64'(1'b1));
    nextCycle();
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
    applyStimulus(mkReq(0, A0, D0, 1'b0), mkReq(0, A1, D1, 1'b1), mkRsp(1, 32'h77777777));
    settle();
    checkAll("rstwait late", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkReq("rstwait late", 32'h0, 32'h0, 1'b0);
    nextCycle();

    // Randomized traffic against a transaction-level model.
    doReset();
    begin
      int          mOwner;
      int          mAge;
      int          mLast;
      logic        mTo;
      logic [31:0] mAddr;
      logic [31:0] mData;
      logic        mRw;
      bit          act[2];
      bit          drop[2];
      logic [31:0] ra[2];
      logic [31:0] rd[2];
      logic        rrw[2];
      mOwner = -1; mAge = 0; mLast = 1; mTo = 1'b0;
      mAddr = '0; mData = '0; mRw = 1'b0;
      for (int p = 0; p < 2; p++) begin
        act[p] = 0; drop[p] = 0; ra[p] = '0; rd[p] = '0; rrw[p] = 1'b0;
      end
      for (int cyc = 0; cyc < 500; cyc++) begin
        logic        mrdy;
        logic [31:0] mdata;
        logic        done;
        logic        abort;
        logic [31:0] eData;
        logic [1:0]  eGrant;
        string       tag;
        tag = $sformatf("rnd%0d", cyc);
        for (int p = 0; p < 2; p++) begin
          if (drop[p]) begin
            act[p]  = 0;
            drop[p] = 0;
          end else if (!act[p] && $urandom_range(0, 2) == 0) begin
            act[p] = 1;
            ra[p]  = $urandom;
            rd[p]  = $urandom;
            rrw[p] = 1'($urandom_range(0, 1));
          end
        end
        mrdy  = ($urandom_range(0, 5) == 0);
        mdata = $urandom;
        applyStimulus(mkReq(act[0], ra[0], rd[0], rrw[0]), mkReq(act[1], ra[1], rd[1], rrw[1]),
                      mkRsp(mrdy, mdata));
        settle();

        done = 1'b0; abort = 1'b0; eData = 32'h0;
        if (mOwner >= 0 && mAge >= 2) begin
          if (mrdy) begin
            done = 1'b1; eData = mdata;
          end else if (mAge - 2 == TIMEOUT - 1) begin
            done = 1'b1; abort = 1'b1;
          end
        end
        eGrant = (mOwner < 0) ? 2'b00 : ((mOwner == 0) ? 2'b01 : 2'b10);
        checkAll(tag, eGrant, mOwner >= 0, mOwner >= 0 && mAge == 1,
                 done && mOwner == 0, (done && mOwner == 0) ? eData : 32'h0,
                 done && mOwner == 1, (done && mOwner == 1) ? eData : 32'h0, mTo);
        if (mOwner >= 0) checkReq(tag, mAddr, mData, mRw);

        if (mOwner < 0) begin
          if (act[0] || act[1]) begin
            int win;
            win = (act[0] && act[1]) ? (1 - mLast) : (act[0] ? 0 : 1);
            mOwner = win;
            mAge   = 1;
            mAddr  = ra[win];
            mData  = rd[win];
            mRw    = rrw[win];
          end
        end else if (done) begin
          mLast        = mOwner;
          drop[mOwner] = 1;
          if (abort) mTo = 1'b1;
          mOwner       = -1;
        end else begin
          mAge++;
        end
        nextCycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single synchronous-SRAM controller between the instruction cache (port 0) and the data cache (port 1). Each cache sees a private `cache_to_mem_type` / `mem_to_cache_type` channel. The arbiter serialises their requests onto the one memory-side channel, holds the granted request stable until the controller signals completion, and routes the response back to the granted requester only. A watchdog aborts a transaction that never completes.

## Interface
- `TIMEOUT_CYCLES`, 16: max cycles in WAIT before abort; legal range 2..255.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `req0`  in  `cache_to_mem_type`  port 0 (I-cache) request: `addr`, `data`, `rw`, `valid`
- `rsp0`  out  `mem_to_cache_type`  port 0 response: `data`, `ready`
- `req1`  in  `cache_to_mem_type`  port 1 (D-cache) request
- `rsp1`  out  `mem_to_cache_type`  port 1 response
- `mem_req`  out  `cache_to_mem_type`  request to SRAM controller
- `mem_rsp`  in  `mem_to_cache_type`  response from SRAM controller
- `grant`  out  2  one-hot owner of the memory channel; 0 when idle
- `busy`  out  1  transaction in flight (state ≠ IDLE)
- `timeout_err`  out  1  sticky; set on any watchdog abort

## Operation
- Requester contract:
  - Assert `valid` and hold `addr`/`data`/`rw` stable until its `ready` pulses.
  - Drop `valid` in the cycle after `ready`.
- States:
  - **IDLE**
    - No valid request: stay.
    - One valid request: grant it.
    - Both valid: grant the port not granted last. `last_grant` resets to port 1, so port 0 wins the first tie.
    - On grant: register `addr`/`data`/`rw` into `mem_req`, set `grant`, go to ISSUE.
  - **ISSUE**
    - `mem_req.valid`=1 for exactly this one cycle; fields stay latched.
    - Go to WAIT and clear the watchdog counter.
  - **WAIT**
    - `mem_req.valid`=0; `addr`/`data`/`rw` held.
    - Counter increments each cycle.
    - `mem_rsp.ready`=1: combinationally drive granted `rsp.ready`=1 and `rsp.data`=`mem_rsp.data`. Update `last_grant`, go to IDLE.
    - Counter reaches `TIMEOUT_CYCLES-1` without ready: drive granted `rsp.ready`=1 with `rsp.data`=0, set `timeout_err`, update `last_grant`, go to IDLE.
- Response routing:
  - Non-granted port always has `rsp.ready`=0 and `rsp.data`=0.
  - `mem_rsp.ready` outside WAIT is ignored.
- `mem_req.valid` is a single-cycle pulse. Re-asserting it would make the controller start a second access.
- A requester whose `valid` drops while granted is not cancelled: the transaction completes and `ready` still pulses.

## Timing
- Reset: state IDLE, `mem_req`=0 (all fields), `rsp0`/`rsp1`=0, `grant`=0, `busy`=0, `timeout_err`=0, counter=0, `last_grant`=port 1.
- Reset mid-transaction: abort immediately to reset values. A late `mem_rsp.ready` is ignored; no requester gets `ready`.
- Latency:
  - Request seen in IDLE at cycle N.
  - ISSUE and `mem_req.valid` high at N+1.
  - WAIT from N+2.
  - Requester `ready` in the same cycle as `mem_rsp.ready`; earliest is N+2.
- Back-to-back: IDLE is always visited for one cycle between transactions. Minimum spacing is 3 cycles plus memory latency.
- Simultaneous completion and new request: a request from the other port in the `ready` cycle is evaluated in the following IDLE cycle.
- Timeout abort occurs in the `TIMEOUT_CYCLES`-th WAIT cycle.
- Counter width is 8 bits; it never wraps because it is bounded by `TIMEOUT_CYCLES`.

## Structure
- Package `cache_definition` (shared; existing types reused):
  - Add `arb_state_type` (IDLE, ISSUE, WAIT).
  - Add `ARB_TIMEOUT_DEFAULT` = 16.
  - `cache_to_mem_type` / `mem_to_cache_type` are unchanged.
- Sub-module `rr_pick2`: combinational 2-way round-robin chooser (`valid0`, `valid1`, `last_grant` → one-hot grant). Keeps the FSM independent of the fairness policy.
- Single `always_ff` for state, latched request, `grant`, `last_grant`, counter and `timeout_err`; single `always_comb` for next state and response routing.

## Test plan
- Port 0 single read, `addr`=0x00040, memory returns 0xDEADBEEF 2 cycles after issue → `mem_req.valid` pulses exactly 1 cycle; `rsp0.ready`=1 with data 0xDEADBEEF; `rsp1` stays 0.
- Both ports request in the same cycle after reset → port 0 granted first; port 1 issued in the cycle after port 0's IDLE; `grant` sequence 01, 00, 10.
- Port 1 write (`addr`=0x12345, `data`=0xA5A5A5A5) with port 0 idle → `mem_req.rw`=1, `addr`/`data` held unchanged through WAIT; `rsp1.ready` pulses once.
- Both ports requesting continuously for 6 transactions → strict alternation 0,1,0,1,0,1; no back-to-back grant to the same port.
- Memory never asserts ready, `TIMEOUT_CYCLES`=16 → after 16 WAIT cycles granted `rsp.ready`=1 with data 0; `timeout_err`=1 and stays 1 until reset.
- `rst`=0 during WAIT, then `mem_rsp.ready` pulses → all outputs at reset values; no `rsp.ready` on either port.
